// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// Op codes follow the RISC-V M-extension func3 encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic hi_half(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator pair.
// Multiply: shift-add, lo holds the remaining multiplier bits.
// Divide: restoring shift-subtract, hi is the partial remainder, lo the
// dividend shifting out / quotient shifting in.
// A single WIDTH+1 bit adder serves both modes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] add_x;
    logic [WIDTH:0] add_y;
    logic           add_cin;
    logic [WIDTH:0] add_sum;
    logic           neg;

    // Shared adder: add multiplicand or subtract divisor.
    always_comb begin
        if (mode_div) begin
            add_x   = {hi, lo[WIDTH-1]};
            add_y   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, hi};
            add_y   = lo[0] ? {1'b0, opnd} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
    end

    // Shift the accumulator; in divide mode a negative difference restores.
    always_comb begin
        neg = add_sum[WIDTH];
        if (mode_div) begin
            hi_nxt = neg ? add_x[WIDTH-1:0] : add_sum[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ~neg};
        end else begin
            {hi_nxt, lo_nxt} = {add_sum, lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative radix-2 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// One transaction at a time: start while idle, busy until the one-cycle valid.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH shift-add / shift-subtract iterations
// FIX   | sign correction and result select
// DONE  | valid pulse, result/div0 registered
module iter_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state;
    md_state_e          state_nxt;
    md_op_e             op_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   result_r;
    logic               div0_r;

    logic               accept;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               b_zero;
    logic               div_ovf;
    logic               special;
    logic [WIDTH-1:0]   special_res;

    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic               calc_done;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;

    // Decode the request: magnitudes, signs and the no-iteration cases.
    always_comb begin
        accept  = (state == IDLE) && start && !flush;
        sgn_a   = is_signed_a(op) && a[WIDTH-1];
        sgn_b   = is_signed_b(op) && b[WIDTH-1];
        mag_a   = sgn_a ? -a : a;
        mag_b   = sgn_b ? -b : b;
        b_zero  = (b == '0);
        div_ovf = is_div(op) && is_signed_b(op) && (a == MIN_VAL) && (b == '1);
        special = is_div(op) && (b_zero || div_ovf);
        if (b_zero) begin
            special_res = is_rem(op) ? a : '1;
        end else begin
            special_res = is_rem(op) ? '0 : MIN_VAL;
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_div (is_div(op_r)),
        .hi       (acc_hi),
        .lo       (acc_lo),
        .opnd     (opnd),
        .hi_nxt   (step_hi),
        .lo_nxt   (step_lo)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0]   cnt_rem;
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH-1:0] early_acc;
    logic               early_out;

    // Multiply exits once the multiplier bits still to be consumed are zero;
    // the skipped iterations reduce to a plain right shift.
    always_comb begin
        cnt_rem   = cnt - CNT_W'(1);
        rem_mask  = (WIDTH'(1) << cnt_rem) - WIDTH'(1);
        early_acc = {step_hi, step_lo} >> cnt_rem;
        early_out = !is_div(op_r) && ((step_lo & rem_mask) == '0);
        calc_done = (cnt == CNT_W'(1)) || early_out;
        if (early_out) begin
            nxt_hi = early_acc[2*WIDTH-1:WIDTH];
            nxt_lo = early_acc[WIDTH-1:0];
        end else begin
            nxt_hi = step_hi;
            nxt_lo = step_lo;
        end
    end
`else
    // Fixed iteration count: terminal count on the down-counter.
    always_comb begin
        calc_done = (cnt == CNT_W'(1));
        nxt_hi    = step_hi;
        nxt_lo    = step_lo;
    end
`endif

    // Sign fix-up of the raw magnitude result and output half selection.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
        if (is_div(op_r)) begin
            fix_res = is_rem(op_r) ? rem_fix : quo_fix;
        end else if (hi_half(op_r)) begin
            fix_res = prod_fix[2*WIDTH-1:WIDTH];
        end else begin
            fix_res = prod_fix[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush aborts only the working states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (calc_done) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    // Operand capture, iteration, and result registration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r     <= OP_MUL;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_r <= '0;
            div0_r   <= 1'b0;
        end else if (accept) begin
            op_r    <= op;
            cnt     <= CNT_LOAD;
            acc_hi  <= '0;
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            if (is_div(op)) begin
                acc_lo <= mag_a;
                opnd   <= mag_b;
            end else begin
                acc_lo <= mag_b;
                opnd   <= mag_a;
            end
            if (special) begin
                result_r <= special_res;
                div0_r   <= b_zero;
            end
        end else if (state == CALC) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - CNT_W'(1);
        end else if ((state == FIX) && !flush) begin
            result_r <= fix_res;
            div0_r   <= 1'b0;
        end
    end

    assign result = result_r;
    assign div0   = div0_r;

endmodule
